// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample, binary search, result.
// Comparator input is double-synchronised before each bit decision.
module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0] WIN_LAST    = 8'(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       cmp_sync;
    logic             cmp_s;
    logic [7:0]       cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] bit_i;
    logic [WIDTH-1:0] kept;

    assign cmp_s = cmp_sync[1];
    assign bit_i = WIDTH'(1) << idx;
    assign kept  = cmp_s ? dac_code : (dac_code & ~bit_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_sync <= '0;
        end else begin
            cmp_sync <= {cmp_sync[0], cmp_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dac_code <= '0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            if (!ena) begin
                state    <= IDLE;
                cnt      <= '0;
                sample   <= 1'b0;
                busy     <= 1'b0;
                dac_code <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= SAMPLE;
                            cnt    <= '0;
                            sample <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (cnt == SAMPLE_LAST) begin
                            state    <= CONVERT;
                            cnt      <= '0;
                            sample   <= 1'b0;
                            idx      <= IW'(WIDTH - 1);
                            dac_code <= WIDTH'(1) << (WIDTH - 1);
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    CONVERT: begin
                        // decide on the last cycle of the window, once cmp_s has settled
                        if (cnt == WIN_LAST) begin
                            cnt <= '0;
                            if (idx == '0) begin
                                state    <= DONE;
                                dac_code <= kept;
                            end else begin
                                idx      <= idx - IW'(1);
                                dac_code <= kept | (bit_i >> 1);
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    DONE: begin
                        // result and the done pulse are registered on leaving DONE
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= dac_code;
                        dac_code <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model.
// Stimulus pushes expected results; a monitor checks each done pulse.
module tb_sar_adc_ctrl;

    localparam int LAT = 37;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       cmp_in;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] vin;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    int   n_done = 0;

    sar_adc_ctrl #(
        .WIDTH(8),
        .SAMPLE_CYC(4),
        .SETTLE(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .cmp_in(cmp_in),
        .sample(sample),
        .dac_code(dac_code),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    always_comb cmp_in = (vin >= dac_code);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got result 0x%0h expected no pulse (cycle %0d)",
                         result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic start_conv(input logic [7:0] v, input bit push, output int acc);
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) sb.push_back('{res: v, cyc: acc + LAT});
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (n_done < target) begin
            fails++;
            $display("FAIL wait_done: got %0d pulses expected %0d (timeout)",
                     n_done, target);
        end
    endtask

    initial begin
        logic [7:0] seq [8];
        logic [7:0] vals [4];
        int a;
        int exp_done;
        seq  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vals = '{8'hFF, 8'h00, 8'h80, 8'h3C};
        exp_done = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        vin   = 8'h00;

        #23;
        chk("rst_sample", int'(sample), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        start_conv(8'hA5, 1'b1, a);
        chk("acc_busy", int'(busy), 1);
        chk("acc_sample", int'(sample), 1);
        chk("acc_dac", int'(dac_code), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("conv_sample", int'(sample), 0);
        for (int w = 0; w < 8; w++) begin
            chk($sformatf("win%0d_dac", w), int'(dac_code), int'(seq[w]));
            repeat (4) @(posedge clk);
            #1;
        end
        chk("donestate_dac", int'(dac_code), 8'hA5);
        chk("donestate_busy", int'(busy), 1);
        exp_done++;
        wait_done(exp_done);
        chk("post_busy", int'(busy), 0);

        for (int k = 0; k < 3; k++) begin
            start_conv(vals[k], 1'b1, a);
            exp_done++;
            wait_done(exp_done);
        end

        @(negedge clk);
        vin   = vals[3];
        start = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        for (int k = 0; k < 3; k++) sb.push_back('{res: vals[3], cyc: a + LAT + 38 * k});
        repeat (113) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_done += 3;
        wait_done(exp_done);

        start_conv(8'h5A, 1'b0, a);
        repeat (19) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sample", int'(sample), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_result", int'(result), 8'h3C);
        @(negedge clk);
        ena = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_done", n_done, exp_done);
        start_conv(8'h5A, 1'b1, a);
        exp_done++;
        wait_done(exp_done);

        start_conv(8'h77, 1'b0, a);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_dac", int'(dac_code), 0);
        chk("arst_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("arst_no_done", n_done, exp_done);
        start_conv(8'h33, 1'b1, a);
        exp_done++;
        wait_done(exp_done);

        start_conv(8'h96, 1'b1, a);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_done++;
        wait_done(exp_done);
        repeat (60) @(negedge clk);
        chk("one_done_per_start", n_done, exp_done);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
